// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the seq_detect_ctrl sequence detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [15:0] DEF_PATTERN = 16'b1011;
    localparam int          DEF_LEN     = 4;
    localparam int          DEF_TARGET  = 1;
    localparam int          DEF_TIMEOUT = 0;

    function automatic logic len_ok(input int len, input int max_len);
        return (len >= 2) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Overlapping Mealy matcher: shift history, bits-seen counter and masked compare.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               z
);

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   bits_seen;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               seen_ok;
    logic               pat_ok;

    // Candidate window is the stored history plus the bit arriving this cycle.
    always_comb begin
        cand = {hist, x};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign seen_ok = ({1'b0, bits_seen} + (LEN_W + 1)'(1)) >= {1'b0, len};
    assign pat_ok  = ((cand ^ pattern) & mask) == '0;
    assign z       = en & seen_ok & pat_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (clr) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (en) begin
            hist <= cand[MAX_LEN-2:0];
            if (bits_seen != LEN_W'(MAX_LEN)) begin
                bits_seen <= bits_seen + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: config registers, FSM, match/timeout counters.
// Optional irq/irq_ack handshake is built when SEQ_CTRL_IRQ_EN is defined.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic               timeout_flag,
    output logic [CNT_W-1:0]   match_cnt
`ifdef SEQ_CTRL_IRQ_EN
    ,
    input  logic               irq_ack,
    output logic               irq
`endif
);

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] cur_pattern;
    logic [LEN_W-1:0]   cur_len;
    logic [CNT_W-1:0]   cur_target;
    logic [TO_W-1:0]    cur_timeout;
    logic [TO_W-1:0]    tmo_cnt;
    logic               armed;
    logic               arm;
    logic               final_match;
    logic               tmo_hit;

    assign armed = (state == ARMED);
    assign arm   = (state_next == ARMED) && !armed;

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (arm),
        .en      (armed & x_valid),
        .x       (x),
        .pattern (cur_pattern),
        .len     (cur_len),
        .z       (z)
    );

    assign final_match = z && (cur_target != '0) &&
                         ((match_cnt + CNT_W'(1)) == cur_target);
    assign tmo_hit     = (cur_timeout != '0) &&
                         (tmo_cnt == (cur_timeout - TO_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks start; a completing match outranks a same-cycle timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start && !abort) state_next = ARMED;
            end
            ARMED: begin
                if (abort)            state_next = IDLE;
                else if (final_match) state_next = DONE;
                else if (tmo_hit)     state_next = TIMEOUT;
            end
            DONE, TIMEOUT: begin
                if (abort)      state_next = IDLE;
                else if (start) state_next = ARMED;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == ARMED);
        done         = (state == DONE);
        timeout_flag = (state == TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_pattern <= MAX_LEN'(DEF_PATTERN);
            cur_len     <= LEN_W'(DEF_LEN);
            cur_target  <= CNT_W'(DEF_TARGET);
            cur_timeout <= TO_W'(DEF_TIMEOUT);
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we && (state == IDLE)) begin
                if (len_ok(int'(cfg_len), MAX_LEN)) begin
                    cur_pattern <= cfg_pattern;
                    cur_len     <= cfg_len;
                    cur_target  <= cfg_target;
                    cur_timeout <= cfg_timeout;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    // match_cnt survives an abort; only arming clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
            tmo_cnt   <= '0;
        end else if (arm) begin
            match_cnt <= '0;
            tmo_cnt   <= '0;
        end else if (armed) begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
            if (z && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_CTRL_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (armed && ((state_next == DONE) || (state_next == TIMEOUT))) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (MAX_LEN 8, CNT_W 8, TO_W 16).
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        cfg_err;
    logic        start;
    logic        abort;
    logic        x;
    logic        x_valid;
    logic        z;
    logic        busy;
    logic        done;
    logic        timeout_flag;
    logic [7:0]  match_cnt;
`ifdef SEQ_CTRL_IRQ_EN
    logic        irq_ack;
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    seq_detect_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_target   (cfg_target),
        .cfg_timeout  (cfg_timeout),
        .cfg_err      (cfg_err),
        .start        (start),
        .abort        (abort),
        .x            (x),
        .x_valid      (x_valid),
        .z            (z),
        .busy         (busy),
        .done         (done),
        .timeout_flag (timeout_flag),
        .match_cnt    (match_cnt)
`ifdef SEQ_CTRL_IRQ_EN
        ,
        .irq_ack      (irq_ack),
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                       input logic [7:0] t, input logic [15:0] to);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_target  = t;
        cfg_timeout = to;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic exp_z, input string tag);
        x       = b;
        x_valid = 1'b1;
        #1;
        chk(tag, z, exp_z);
        tick();
        x_valid = 1'b0;
    endtask

    logic [6:0] s1_bits;
    logic [6:0] s1_z;

    initial begin
        reset = 1'b1;
        cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_target = 0; cfg_timeout = 0;
        start = 0; abort = 0; x = 0; x_valid = 0;
`ifdef SEQ_CTRL_IRQ_EN
        irq_ack = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout_flag, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_z", z, 0);
        reset = 1'b0;
        tick();

        // 1: overlapping detection of 1011 with target 2
        cfg(8'b1011, 4'd4, 8'd2, 16'd0);
        chk("t1_cfg_ok", cfg_err, 0);
        do_start();
        chk("t1_busy", busy, 1);
        s1_bits = 7'b1011011;
        s1_z    = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t1_done_early%0d", i), done, 0);
            bit_in(s1_bits[6-i], s1_z[6-i], $sformatf("t1_z%0d", i + 1));
        end
        chk("t1_done", done, 1);
        chk("t1_busy_off", busy, 0);
        chk("t1_cnt", match_cnt, 2);

        // 2: timeout 5 with constant x=0, target 0
        do_abort();
        chk("t2_idle", done, 0);
        cfg(8'b1011, 4'd4, 8'd0, 16'd5);
        do_start();
        x = 1'b0;
        x_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("t2_tmo_c%0d", k), timeout_flag, (k == 5) ? 1 : 0);
        end
        x_valid = 1'b0;
        chk("t2_cnt", match_cnt, 0);
        chk("t2_busy", busy, 0);

        // 3: rejected lengths, then ignored write while armed
        do_abort();
        cfg(8'b1011, 4'd4, 8'd0, 16'd0);
        chk("t3_valid_cfg", cfg_err, 0);
        cfg(8'h11, 4'd0, 8'd1, 16'd3);
        chk("t3_err_len0", cfg_err, 1);
        tick();
        chk("t3_err_pulse", cfg_err, 0);
        cfg(8'h11, 4'd9, 8'd1, 16'd3);
        chk("t3_err_len9", cfg_err, 1);
        do_start();
        bit_in(1, 0, "t3_b1");
        bit_in(0, 0, "t3_b2");
        bit_in(1, 0, "t3_b3");
        bit_in(1, 1, "t3_b4");
        chk("t3_cnt", match_cnt, 1);
        cfg(8'b11, 4'd2, 8'd1, 16'd0);
        chk("t3_armed_noerr", cfg_err, 0);
        bit_in(1, 0, "t3_b5");
        bit_in(1, 0, "t3_b6");
        chk("t3_still_busy", busy, 1);
        chk("t3_cnt2", match_cnt, 1);

        // 4: idle bits ignored, arming clears history, abort keeps count
        do_abort();
        chk("t4_abort_idle", busy, 0);
        chk("t4_cnt_kept", match_cnt, 1);
        bit_in(1, 0, "t4_idle1");
        bit_in(0, 0, "t4_idle2");
        bit_in(1, 0, "t4_idle3");
        do_start();
        chk("t4_cnt_clr", match_cnt, 0);
        bit_in(1, 0, "t4_hist_clr");
        bit_in(0, 0, "t4_b2");
        bit_in(1, 0, "t4_b3");
        bit_in(1, 1, "t4_b4");
        bit_in(1, 0, "t4_b5");
        bit_in(0, 0, "t4_b6");
        do_abort();
        chk("t4_mid_abort", busy, 0);
        chk("t4_mid_cnt", match_cnt, 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t4_abort_wins", busy, 0);

        // 5: match on the cycle the timeout would fire
        cfg(8'b1011, 4'd4, 8'd1, 16'd4);
        do_start();
        bit_in(1, 0, "t5_b1");
        bit_in(0, 0, "t5_b2");
        bit_in(1, 0, "t5_b3");
        bit_in(1, 1, "t5_b4");
        chk("t5_done", done, 1);
        chk("t5_no_tmo", timeout_flag, 0);
`ifdef SEQ_CTRL_IRQ_EN
        chk("t5_irq_set", irq, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t5_irq_clr", irq, 0);
`endif

        // 6: asynchronous reset while armed, then defaults restored
        do_abort();
        cfg(8'b1011, 4'd4, 8'd0, 16'd0);
        do_start();
        bit_in(1, 0, "t6_b1");
        bit_in(0, 0, "t6_b2");
        bit_in(1, 0, "t6_b3");
        bit_in(1, 1, "t6_b4");
        bit_in(0, 0, "t6_b5");
        bit_in(1, 0, "t6_b6");
        x = 1'b1;
        x_valid = 1'b1;
        #1;
        chk("t6_z_pre", z, 1);
        chk("t6_cnt_pre", match_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", match_cnt, 0);
        chk("t6_rst_z", z, 0);
        x_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        do_start();
        bit_in(1, 0, "t6_def_b1");
        bit_in(0, 0, "t6_def_b2");
        bit_in(1, 0, "t6_def_b3");
        bit_in(1, 1, "t6_def_b4");
        chk("t6_def_done", done, 1);
        chk("t6_def_cnt", match_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Controller and sequencer for a programmable overlapping Mealy sequence detector on a serial bit stream x.
- Holds the pattern configuration, arms and disarms detection, and counts matches toward a target.
- Enforces an optional cycle timeout and reports completion status to the surrounding control logic.
- Wraps the matcher datapath, which is a separate sub-module.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of the match counter and target
TO_W, 16, width of the timeout counter
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  configuration write strobe; honoured only in IDLE
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_target  in  CNT_W  matches required for DONE; 0 = count forever
cfg_timeout  in  TO_W  ARMED cycles before TIMEOUT; 0 = timeout disabled
cfg_err  out  1  one-cycle pulse: configuration write rejected
start  in  1  arm detection (pulse)
abort  in  1  return to IDLE (pulse)
x  in  1  serial data bit
x_valid  in  1  x is sampled this cycle
z  out  1  Mealy match: combinational, same cycle as the last pattern bit
busy  out  1  state == ARMED
done  out  1  state == DONE
timeout_flag  out  1  state == TIMEOUT
match_cnt  out  CNT_W  matches since the last start

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state IDLE; busy, done, timeout_flag, cfg_err, z all 0; match_cnt 0; history and counters 0.
  - Configuration registers: pattern 'b1011, len 4, target 1, timeout 0.
- States: IDLE, ARMED, DONE, TIMEOUT (2-bit encoding).
  - IDLE, start=1 → ARMED.
  - ARMED, abort=1 → IDLE.
  - ARMED, match makes match_cnt == cfg_target (target != 0) → DONE.
  - ARMED, tmo_cnt == cfg_timeout-1 on this cycle (timeout != 0) → TIMEOUT.
  - DONE or TIMEOUT, start=1 → ARMED.
  - DONE or TIMEOUT, abort=1 → IDLE.
  - Priority: abort beats start. A final match beats a timeout in the same cycle; the state goes to DONE.
- Arming (the transition into ARMED) clears history, bits_seen, tmo_cnt and match_cnt. Leaving ARMED via abort keeps match_cnt.
- Config write:
  - Accepted only in IDLE.
  - Rejected when cfg_len < 2 or cfg_len > MAX_LEN: registers unchanged, cfg_err pulses 1 cycle.
  - cfg_we outside IDLE: ignored silently, no cfg_err.
- Matching:
  - Operates only in ARMED with x_valid=1.
  - hist <= {hist[MAX_LEN-2:0], x}.
  - bits_seen increments and saturates at MAX_LEN.
  - z = ARMED & x_valid & (bits_seen >= len-1) & ({hist[len-2:0], x} == pattern[len-1:0]).
  - Detection is overlapping; history is not cleared on a match.
- Counting:
  - match_cnt increments on each z.
  - With cfg_target 0, it saturates at all-ones and DONE is never reached.
- Timeout:
  - tmo_cnt counts every ARMED cycle, whether or not x_valid is high.
- Latency: z is zero-cycle (combinational). done and timeout_flag assert the cycle after the triggering edge.
- Bits are ignored when x_valid=0, and in every state other than ARMED.
- Reset mid-operation: immediate return to reset values, including the configuration registers.

Optional Feature:
SEQ_CTRL_IRQ_EN:
- Defined:
  - Adds input irq_ack and output irq (1 bit, registered, reset 0).
  - irq sets on entry to DONE or TIMEOUT and clears on irq_ack.
  - If set and ack occur in the same cycle, set wins.
- Undefined: neither port exists, and there is no irq logic.

Decomposition:
- Package seq_detect_pkg:
  - state typedef and encodings: IDLE=0, ARMED=1, DONE=2, TIMEOUT=3.
  - Default pattern, length, target and timeout constants.
- Sub-module seq_match_core:
  - Contains hist, bits_seen and the comparator.
  - Inputs: clk, reset, clr, en, x, pattern, len. Output: z.
- seq_detect_ctrl holds the FSM, the configuration registers and all counters.

Test Plan:
1. Defaults (1011, len 4), target 2, start, stream 1,0,1,1,0,1,1 → z on bits 4 and 7 (overlap); done=1 the cycle after bit 7; match_cnt=2; busy=0.
2. Target 0, timeout 5, start, x=0 constant → timeout_flag=1 exactly 5 cycles after entering ARMED; match_cnt=0.
3. cfg_len 0, then cfg_len 9, with MAX_LEN 8 → two cfg_err pulses; pattern and len unchanged. cfg_we while ARMED → no change, no cfg_err.
4. Bits 1,0,1 in IDLE, then start, then 1 → no z (history cleared). Abort mid-stream → IDLE with match_cnt retained. start together with abort → IDLE.
5. Target 1, timeout 4, final bit of 1011 on the 4th ARMED cycle → DONE, not TIMEOUT.
6. reset asserted mid-ARMED between clock edges → busy, match_cnt and z drop to 0 immediately. With SEQ_CTRL_IRQ_EN: irq rises on DONE and clears on irq_ack.
